// File: rtl/video_pkg.sv
// Shared definitions for the video source path: FSM encoding and default stream geometry.
package video_pkg;

  localparam int VIDEO_PIX_W   = 8;
  localparam int VIDEO_N_PIXEL = 480000;

  localparam logic [1:0] VSM_IDLE   = 2'd0;
  localparam logic [1:0] VSM_START  = 2'd1;
  localparam logic [1:0] VSM_STREAM = 2'd2;
  localparam logic [1:0] VSM_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = VSM_IDLE,
    ST_START  = VSM_START,
    ST_STREAM = VSM_STREAM,
    ST_DONE   = VSM_DONE
  } vsm_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for slow asynchronous inputs such as DIP switches.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_10M,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk_10M) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/video_source_mux.sv
// N-way pixel source selector; the source is latched per frame so a frame never mixes sources.
//
//   state  | meaning
//   IDLE   | no source active; waits for frame_start, then latches the synced select
//   START  | start request to the latched source; waits for that source's ack
//   STREAM | combinational pass-through of the latched source, counting handshakes
//   DONE   | single cycle; frame counted on exit
module video_source_mux
  import video_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int SEL_W   = 2,
  parameter int PIX_W   = VIDEO_PIX_W,
  parameter int N_PIXEL = VIDEO_N_PIXEL,
  parameter int CNT_W   = 19
) (
  input  logic                     clk_10M,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     frame_start,
  output logic                     frame_start_ack,
  output logic [N_SRC-1:0]         src_start,
  input  logic [N_SRC-1:0]         src_start_ack,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC*PIX_W-1:0]   src_pixel,
  output logic [N_SRC-1:0]         src_ready,
  output logic                     out_valid,
  output logic [PIX_W-1:0]         out_pixel,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         active_src,
  output logic [7:0]               frame_count,
  output logic                     switch_pending,
  output logic                     sel_error
);

  localparam logic [31:0]      N_SRC_U  = N_SRC;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIXEL - 1);

  logic [SEL_W-1:0] sel_s;
  logic             sel_oob;
  vsm_state_t       state, state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic [N_SRC-1:0] active_onehot;
  logic             act_valid, act_ack, handshake, last_pix;
  logic [PIX_W-1:0] act_pixel;

  sync2 #(.W(SEL_W)) u_sel_sync (
    .clk_10M (clk_10M),
    .reset   (reset),
    .d       (sel),
    .q       (sel_s)
  );

  assign sel_oob        = 32'(sel_s) >= N_SRC_U;
  assign sel_error      = sel_oob;
  assign switch_pending = (sel_s != active_src);

  assign active_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << active_src;
  assign act_valid     = src_valid[active_src];
  assign act_ack       = src_start_ack[active_src];
  assign act_pixel     = src_pixel[active_src*PIX_W +: PIX_W];
  assign handshake     = act_valid & out_ready;
  assign last_pix      = (pix_cnt == LAST_PIX);

  always_comb begin
    state_nxt = state;
    src_start = '0;
    src_ready = '0;
    out_valid = 1'b0;
    out_pixel = '0;
    case (state)
      ST_IDLE: begin
        if (frame_start) state_nxt = ST_START;
      end
      ST_START: begin
        src_start = active_onehot;
        if (act_ack) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        out_valid = act_valid;
        out_pixel = act_pixel;
        src_ready = active_onehot & {N_SRC{out_ready}};
        if (handshake && last_pix) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_10M) begin
    if (reset) begin
      state           <= ST_IDLE;
      active_src      <= '0;
      pix_cnt         <= '0;
      frame_count     <= '0;
      frame_start_ack <= 1'b0;
    end else begin
      state           <= state_nxt;
      frame_start_ack <= (state == ST_START) && act_ack;
      // Out-of-range selections fall back to source 0 rather than an unconnected index.
      if (state == ST_IDLE && frame_start)
        active_src <= sel_oob ? '0 : sel_s;
      if (state == ST_START && act_ack)
        pix_cnt <= '0;
      else if (state == ST_STREAM && handshake)
        pix_cnt <= last_pix ? '0 : pix_cnt + CNT_W'(1);
      if (state == ST_DONE)
        frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_video_source_mux.sv
// Directed bench for video_source_mux with 16-pixel frames; a 3-source instance covers out-of-range select.
module tb_video_source_mux;

  logic        clk_10M = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        frame_start, frame_start_ack;
  logic [3:0]  src_start, src_start_ack, src_valid, src_ready;
  logic [31:0] src_pixel;
  logic        out_valid, out_ready;
  logic [7:0]  out_pixel, frame_count;
  logic [1:0]  active_src;
  logic        switch_pending, sel_error;

  logic [1:0]  b_sel;
  logic        b_frame_start, b_fsa;
  logic [2:0]  b_src_start, b_ack, b_valid, b_ready;
  logic [23:0] b_pixel;
  logic        b_out_valid, b_out_ready;
  logic [7:0]  b_out_pixel, b_fc;
  logic [1:0]  b_active;
  logic        b_sp, b_se;

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;
  int hs;

  typedef struct packed {
    logic        fs;
    logic [3:0]  ack;
    logic [3:0]  valid;
    logic [31:0] pix;
    logic        rdy;
    logic [27:0] exp;
  } vec_t;

  vec_t tbl [22];

  always #50 clk_10M = ~clk_10M;

  video_source_mux #(.N_SRC(4), .SEL_W(2), .PIX_W(8), .N_PIXEL(16), .CNT_W(5)) dut (
    .clk_10M(clk_10M), .reset(reset), .sel(sel),
    .frame_start(frame_start), .frame_start_ack(frame_start_ack),
    .src_start(src_start), .src_start_ack(src_start_ack),
    .src_valid(src_valid), .src_pixel(src_pixel), .src_ready(src_ready),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_ready(out_ready),
    .active_src(active_src), .frame_count(frame_count),
    .switch_pending(switch_pending), .sel_error(sel_error)
  );

  video_source_mux #(.N_SRC(3), .SEL_W(2), .PIX_W(8), .N_PIXEL(16), .CNT_W(5)) dut_b (
    .clk_10M(clk_10M), .reset(reset), .sel(b_sel),
    .frame_start(b_frame_start), .frame_start_ack(b_fsa),
    .src_start(b_src_start), .src_start_ack(b_ack),
    .src_valid(b_valid), .src_pixel(b_pixel), .src_ready(b_ready),
    .out_valid(b_out_valid), .out_pixel(b_out_pixel), .out_ready(b_out_ready),
    .active_src(b_active), .frame_count(b_fc),
    .switch_pending(b_sp), .sel_error(b_se)
  );

  task automatic cyc();
    @(posedge clk_10M);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] mk(input logic [3:0] ss, input logic [3:0] sr, input logic ov,
                                     input logic [7:0] op, input logic fsa, input logic [7:0] fc,
                                     input logic [1:0] as);
    return {ss, sr, ov, op, fsa, fc, as};
  endfunction

  function automatic logic [27:0] outs();
    return {src_start, src_ready, out_valid, out_pixel, frame_start_ack, frame_count, active_src};
  endfunction

  task automatic set_sel(input logic [1:0] v);
    sel = v;
    repeat (3) cyc();
  endtask

  task automatic start_frame(input int src);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    src_start_ack = 4'(1 << src);
    #5 check("start_req", {src_start, active_src}, {4'(1 << src), 2'(src)});
    cyc();
    src_start_ack = 4'b0;
    #5 check("start_ack_pulse", frame_start_ack, 1);
  endtask

  // Streams until the DUT leaves STREAM; returns in the DONE cycle with the handshake count.
  task automatic stream(input int src, input logic [7:0] base, input bit toggle,
                        input int sw_at, input logic [1:0] sw_sel, output int n_hs);
    logic [3:0] exp_rdy;
    bit done;
    n_hs = 0;
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      out_ready = !toggle || (c % 2 == 0);
      src_valid = 4'b1111;
      for (int s = 0; s < 4; s++)
        src_pixel[s*8 +: 8] = (s == src) ? 8'(base + n_hs) : 8'(224 + c);
      if (n_hs == sw_at) sel = sw_sel;
      #5;
      if (!out_valid) begin
        done = 1'b1;
        break;
      end
      exp_rdy = out_ready ? 4'(1 << src) : 4'b0;
      check("stream_pix", {out_pixel, src_ready}, {8'(base + n_hs), exp_rdy});
      if (out_ready) n_hs++;
      cyc();
    end
    check("stream_end", done, 1);
    src_valid = 4'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 2'd0; frame_start = 1'b0; src_start_ack = '0;
    src_valid = '0; src_pixel = '0; out_ready = 1'b1;
    b_sel = 2'd0; b_frame_start = 1'b0; b_ack = '0; b_valid = '0; b_pixel = '0; b_out_ready = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    #5 check("reset_state", {outs(), switch_pending, sel_error}, {mk(0, 0, 0, 0, 0, 0, 0), 2'b00});

    // Reset at pixel 8 discards the partial frame
    set_sel(2'd1);
    start_frame(1);
    for (int k = 0; k < 8; k++) begin
      src_valid = 4'b0010;
      src_pixel = {8'hEE, 8'hEE, 8'(64 + k), 8'hEE};
      #5 check("pre_reset_pix", out_pixel, 8'(64 + k));
      cyc();
    end
    reset = 1'b1;
    src_valid = '0;
    cyc();
    reset = 1'b0;
    #5 check("reset_mid", {outs(), switch_pending, sel_error}, {mk(0, 0, 0, 0, 0, 0, 0), 2'b00});
    repeat (3) cyc();
    start_frame(1);
    stream(1, 8'h40, 1'b0, -1, 2'd0, hs);
    check("reset_frame_len", hs, 16);
    cyc();
    exp_fc++;
    check("reset_frame_count", frame_count, 8'(exp_fc));

    // Basic frame from source 2, cycle by cycle
    set_sel(2'd2);
    tbl[0] = '{1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1, mk(0, 0, 0, 0, 0, 1, 1)};
    tbl[1] = '{1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1, mk(4'b0100, 0, 0, 0, 0, 1, 2)};
    tbl[2] = '{1'b0, 4'b0001, 4'b0000, 32'h0, 1'b1, mk(4'b0100, 0, 0, 0, 0, 1, 2)};
    tbl[3] = '{1'b0, 4'b0100, 4'b0000, 32'h0, 1'b1, mk(4'b0100, 0, 0, 0, 0, 1, 2)};
    for (int i = 0; i < 16; i++)
      tbl[4+i] = '{1'b0, 4'b0000, 4'b1111, {8'(224 + i), 8'(16 + i), 8'(224 + i), 8'(224 + i)},
                   1'b1, mk(0, 4'b0100, 1, 8'(16 + i), (i == 0), 1, 2)};
    tbl[20] = '{1'b0, 4'b0000, 4'b1111, 32'hE5E5E5E5, 1'b1, mk(0, 0, 0, 0, 0, 1, 2)};
    tbl[21] = '{1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1, mk(0, 0, 0, 0, 0, 2, 2)};
    for (int i = 0; i < 22; i++) begin
      frame_start   = tbl[i].fs;
      src_start_ack = tbl[i].ack;
      src_valid     = tbl[i].valid;
      src_pixel     = tbl[i].pix;
      out_ready     = tbl[i].rdy;
      #5 check($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
      cyc();
    end
    src_valid = '0;
    src_pixel = '0;
    exp_fc = 2;

    // Mid-frame switch 1 -> 3, then back-to-back frame from source 3
    set_sel(2'd1);
    start_frame(1);
    stream(1, 8'h20, 1'b0, 5, 2'd3, hs);
    check("switch_frame_len", hs, 16);
    frame_start = 1'b1;
    check("pending_done", {switch_pending, active_src}, {1'b1, 2'd1});
    cyc();
    exp_fc++;
    #5 check("b2b_idle", {src_start, frame_count, switch_pending}, {4'b0000, 8'(exp_fc), 1'b1});
    cyc();
    frame_start = 1'b0;
    #5 check("b2b_start", {src_start, active_src, switch_pending}, {4'b1000, 2'd3, 1'b0});
    src_start_ack = 4'b1000;
    cyc();
    src_start_ack = 4'b0;
    stream(3, 8'h30, 1'b0, -1, 2'd0, hs);
    check("second_frame_len", hs, 16);
    cyc();
    exp_fc++;
    check("second_frame_count", frame_count, 8'(exp_fc));

    // Backpressure: ready toggles, frame needs exactly 16 handshakes
    set_sel(2'd2);
    start_frame(2);
    stream(2, 8'h70, 1'b1, -1, 2'd0, hs);
    check("bp_handshakes", hs, 16);
    check("bp_done_count", frame_count, 8'(exp_fc));
    cyc();
    exp_fc++;
    check("bp_frame_count", frame_count, 8'(exp_fc));

    // Ack from a non-active source is ignored
    set_sel(2'd1);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    src_start_ack = 4'b0001;
    repeat (3) begin
      #5 check("wrong_ack", {src_start, frame_start_ack, out_valid}, {4'b0010, 1'b0, 1'b0});
      cyc();
    end
    src_start_ack = 4'b0010;
    cyc();
    src_start_ack = 4'b0;
    #5 check("right_ack", {frame_start_ack, src_start}, {1'b1, 4'b0000});
    stream(1, 8'h50, 1'b0, -1, 2'd0, hs);
    check("ack_frame_len", hs, 16);
    cyc();
    exp_fc++;
    check("ack_frame_count", frame_count, 8'(exp_fc));

    // Three-source instance, select 3 is out of range
    b_sel = 2'd3;
    repeat (3) cyc();
    #5 check("oob_flags", {b_se, b_sp}, 2'b11);
    b_frame_start = 1'b1;
    cyc();
    b_frame_start = 1'b0;
    #5 check("oob_start", {b_src_start, b_active}, {3'b001, 2'd0});
    b_ack = 3'b001;
    cyc();
    b_ack = 3'b000;
    for (int k = 0; k < 16; k++) begin
      b_valid = 3'b111;
      b_pixel = {8'(224 + k), 8'(224 + k), 8'(96 + k)};
      #5 check("oob_pix", {b_out_valid, b_out_pixel, b_ready}, {1'b1, 8'(96 + k), 3'b001});
      cyc();
    end
    #5 check("oob_done", {b_out_valid, b_ready}, 4'b0000);
    b_valid = 3'b000;
    cyc();
    check("oob_frame_count", b_fc, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_source_mux.md
# video_source_mux

Parametrised N-way pixel-stream source selector on clk_10M. It replaces the ad-hoc DIP-switch muxing between the static image, VGA capture and filtered streams in front of the image buffer writer. Selection changes take effect only at frame boundaries, so the writer never receives a frame mixed from two sources. The block also tracks per-frame progress and exposes frame count and status for the LEDs.

## Interface
Parameters:
- N_SRC, 4, number of pixel sources (≥2)
- SEL_W, 2, width of select input; ≥ clog2(N_SRC)
- PIX_W, 8, pixel width
- N_PIXEL, 480000, pixels per frame
- CNT_W, 19, pixel counter width; must hold N_PIXEL-1

Ports:
- clk_10M  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sel  in  SEL_W  requested source (asynchronous DIP switches)
- frame_start  in  1  frame request from the buffer writer
- frame_start_ack  out  1  one-cycle pulse: chosen source acknowledged start
- src_start  out  N_SRC  start request, one-hot to the active source
- src_start_ack  in  N_SRC  per-source start acknowledge
- src_valid  in  N_SRC  per-source pixel valid
- src_pixel  in  N_SRC*PIX_W  packed pixels; source i at [i*PIX_W +: PIX_W]
- src_ready  out  N_SRC  per-source ready; only the active bit may be 1
- out_valid  out  1  muxed pixel valid
- out_pixel  out  PIX_W  muxed pixel
- out_ready  in  1  downstream ready; tie to 1 when the sink has no backpressure
- active_src  out  SEL_W  source latched for the current or last frame
- frame_count  out  8  completed frames, wraps 255→0
- switch_pending  out  1  synced sel differs from active_src
- sel_error  out  1  synced sel ≥ N_SRC

## Operation
- sel passes through a 2-flop synchroniser to give sel_s. Only sel_s is used internally.
- Out-of-range selection: sel_s ≥ N_SRC sets sel_error = 1 and latches source 0.
- FSM states IDLE, START, STREAM, DONE:
  - IDLE: all src_start/src_ready = 0, out_valid = 0. If frame_start = 1: latch active_src ← sel_s (clamped as above), go to START.
  - START: src_start[active_src] = 1. When src_start_ack[active_src] = 1: pulse frame_start_ack for one cycle, clear pix_cnt, go to STREAM. Acks from other sources are ignored.
  - STREAM: out_valid = src_valid[active_src]; out_pixel = the active slice; src_ready[active_src] = out_ready; all other ready bits 0. On each out_valid & out_ready, increment pix_cnt. The handshake with pix_cnt = N_PIXEL-1 goes to DONE.
  - DONE: one cycle. frame_count += 1, then go to IDLE.
- sel changes during START, STREAM or DONE are ignored until the next IDLE latch; switch_pending shows them.
- frame_start held high in IDLE after DONE starts the next frame on the following cycle. There is no extra idle gap.
- Reset mid-frame: immediate return to IDLE; the partial frame is not counted.

## Timing
- Reset values: frame_start_ack = 0, src_start = 0, src_ready = 0, out_valid = 0, out_pixel = 0, active_src = 0, frame_count = 0, switch_pending = 0, sel_error = 0. FSM = IDLE, pix_cnt = 0, synchroniser flops = 0.
- sel → sel_s latency: 2 cycles.
- frame_start → src_start asserted: 1 cycle (registered IDLE→START).
- src_start_ack → frame_start_ack high and STREAM entered: next edge. frame_start_ack is registered and lasts exactly 1 cycle.
- STREAM data path is combinational:
  - src_valid/src_pixel → out_valid/out_pixel: 0 cycles.
  - out_ready → src_ready: 0 cycles.
- Final handshake → DONE: next edge. frame_count updates on the DONE→IDLE edge.
- out_pixel is forced to 0 outside STREAM.
- pix_cnt never exceeds N_PIXEL-1.

## Structure
- Shared package video_pkg holds:
  - FSM state encoding localparams (VSM_IDLE, VSM_START, VSM_STREAM, VSM_DONE)
  - default PIX_W and N_PIXEL
- One sub-module: sync2 (parametrised-width 2-flop synchroniser), instantiated for sel and reused for other DIP/switch inputs elsewhere in the design.

## Test plan
Benches override N_PIXEL = 16, CNT_W = 5.
- Basic frame: sel = 2, frame_start pulse, src 2 acks, 16 valid pixels 0x10..0x1F with out_ready = 1 → out_pixel sequence 0x10..0x1F; src_ready = 4'b0100 during STREAM; frame_count 0→1; one frame_start_ack pulse.
- Mid-frame switch: sel 1→3 after pixel 5 → remaining 10 pixels still from src 1; switch_pending = 1 until the next IDLE latch; second frame streams src 3.
- Backpressure: out_ready toggles 1,0,1,0 → pix_cnt advances only on handshake cycles; frame completes after exactly 16 handshakes.
- Out-of-range: N_SRC = 3, sel = 3 → sel_error = 1; src_start = 3'b001; frame taken from src 0.
- Wrong ack: in START, src 0 acks while src 1 is active → stays in START; no frame_start_ack until src 1 acks.
- Reset mid-frame: reset at pixel 8 → all outputs return to reset values next cycle; frame_count unchanged; a new frame_start streams 16 pixels normally.
